// File: rtl/ntsc_line_sequencer_pkg.sv
// NTSC raster timing constants, H-state encodings and colour codes,
// shared with the DAC level mux. Bar pattern used when SEQ_TESTPATTERN_EN is defined.
package ntsc_line_sequencer_pkg;

    localparam int HSYNC_CLKS  = 235;
    localparam int BREEZE_CLKS = 30;
    localparam int BURST_CLKS  = 126;
    localparam int BACK_CLKS   = 154;
    localparam int CLK_PER_PIX = 10;
    localparam int ACTIVE_PIX  = 256;
    localparam int ACTIVE_CLKS = CLK_PER_PIX * ACTIVE_PIX;
    localparam int FRONT_CLKS  = 73;
    localparam int LINE_CLKS   = HSYNC_CLKS + BREEZE_CLKS + BURST_CLKS
                               + BACK_CLKS + ACTIVE_CLKS + FRONT_CLKS;

    localparam int VSYNC_LINES_D  = 3;
    localparam int VBLANK_END_D   = 20;
    localparam int ACTIVE_LINES_D = 240;
    localparam int TOTAL_LINES_D  = 262;

    localparam logic [5:0] BURST_COLOUR = 6'h08;
    localparam logic [5:0] BLACK_COLOUR = 6'h0F;

    localparam int BAR_CLKS = 32 * CLK_PER_PIX;

    typedef enum logic [2:0] {
        H_SYNC,
        H_BREEZE,
        H_BURST,
        H_BACK,
        H_ACTIVE,
        H_FRONT
    } h_state_t;

    function automatic logic [11:0] seg_len(h_state_t s);
        case (s)
            H_SYNC:   return 12'(HSYNC_CLKS);
            H_BREEZE: return 12'(BREEZE_CLKS);
            H_BURST:  return 12'(BURST_CLKS);
            H_BACK:   return 12'(BACK_CLKS);
            H_ACTIVE: return 12'(ACTIVE_CLKS);
            default:  return 12'(FRONT_CLKS);
        endcase
    endfunction

    function automatic h_state_t seg_next(h_state_t s);
        case (s)
            H_SYNC:   return H_BREEZE;
            H_BREEZE: return H_BURST;
            H_BURST:  return H_BACK;
            H_BACK:   return H_ACTIVE;
            H_ACTIVE: return H_FRONT;
            default:  return H_SYNC;
        endcase
    endfunction

    function automatic logic [5:0] bar_colour(logic [11:0] hc);
        if      (hc < 12'(1 * BAR_CLKS)) return 6'h30;
        else if (hc < 12'(2 * BAR_CLKS)) return 6'h28;
        else if (hc < 12'(3 * BAR_CLKS)) return 6'h2C;
        else if (hc < 12'(4 * BAR_CLKS)) return 6'h2A;
        else if (hc < 12'(5 * BAR_CLKS)) return 6'h24;
        else if (hc < 12'(6 * BAR_CLKS)) return 6'h26;
        else if (hc < 12'(7 * BAR_CLKS)) return 6'h22;
        else                             return 6'h0F;
    endfunction

endpackage

// File: rtl/ntsc_h_counter.sv
// Horizontal segment FSM: walks sync..front porch, hcnt reloads per segment,
// line_end flags the last clk of the front porch.
import ntsc_line_sequencer_pkg::*;

module ntsc_h_counter (
    input  logic        clk,
    input  logic        reset,
    output h_state_t    state,
    output logic [11:0] hcnt,
    output logic        line_end
);

    h_state_t    state_nxt;
    logic [11:0] hcnt_nxt;
    logic        last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= H_SYNC;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    always_comb begin
        last      = (hcnt == seg_len(state) - 12'd1);
        state_nxt = state;
        hcnt_nxt  = hcnt + 12'd1;
        line_end  = 1'b0;
        if (last) begin
            state_nxt = seg_next(state);
            hcnt_nxt  = '0;
            line_end  = (state == H_FRONT);
        end
    end

endmodule

// File: rtl/ntsc_line_sequencer.sv
// NTSC line/field sequencer: line counter, pixel fetch and registered
// sync/blank/burst/colour outputs. Define SEQ_TESTPATTERN_EN for colour bars.
import ntsc_line_sequencer_pkg::*;

module ntsc_line_sequencer #(
    parameter int VSYNC_LINES  = VSYNC_LINES_D,
    parameter int VBLANK_END   = VBLANK_END_D,
    parameter int ACTIVE_LINES = ACTIVE_LINES_D,
    parameter int TOTAL_LINES  = TOTAL_LINES_D,
    parameter int PIX_LAT      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pix_colour,
    output logic       pix_req,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic [5:0] colour_num,
    output logic       sync,
    output logic       blank,
    output logic       burst,
    output logic       line_start,
    output logic       frame_start
);

    // Inverted-sync lines drop sync for the final HSYNC_CLKS of the line.
    localparam logic [11:0] VS_ACT_END =
        12'(ACTIVE_CLKS - (HSYNC_CLKS - FRONT_CLKS));

    h_state_t    state;
    logic [11:0] hcnt;
    logic        line_end;
    logic [8:0]  line;
    logic        vs_line;
    logic        act_line;
    logic [5:0]  px;

    logic [5:0]  c_col;
    logic        c_blank;
    logic        c_sync;
    logic        c_burst;
    logic        c_ls;
    logic        c_fs;

    ntsc_h_counter u_hc (
        .clk      (clk),
        .reset    (reset),
        .state    (state),
        .hcnt     (hcnt),
        .line_end (line_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            line <= '0;
        else if (line_end)
            line <= (line == 9'(TOTAL_LINES - 1)) ? '0 : line + 9'd1;
    end

    assign vs_line  = (line < 9'(VSYNC_LINES));
    assign act_line = (line >= 9'(VBLANK_END)) &&
                      (line < 9'(VBLANK_END + ACTIVE_LINES));

`ifdef SEQ_TESTPATTERN_EN
    logic unused_pix;

    assign unused_pix = ^pix_colour;
    assign px         = bar_colour(hcnt);
    assign pix_req    = 1'b0;
    assign pix_x      = '0;
    assign pix_y      = '0;
`else
    localparam int FPH_W = $clog2(CLK_PER_PIX);
    // Pixel n sample must land in pix_buf one clk before its display slot.
    localparam logic [11:0] REQ_START = 12'(BACK_CLKS - 2 - PIX_LAT);

    logic             fetching;
    logic             req_now;
    logic [FPH_W-1:0] fph;
    logic [8:0]       fx;
    logic [PIX_LAT-1:0] req_d;
    logic [5:0]       pix_buf;

    always_comb begin
        req_now = act_line &&
                  ((state == H_BACK && hcnt == REQ_START) ||
                   (fetching && fph == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetching <= 1'b0;
            fph      <= '0;
            fx       <= '0;
            pix_req  <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            req_d    <= '0;
            pix_buf  <= BLACK_COLOUR;
        end else begin
            pix_req <= req_now;
            req_d   <= PIX_LAT'({req_d, pix_req});
            if (req_d[PIX_LAT-1])
                pix_buf <= pix_colour;
            if (line_end) begin
                fetching <= 1'b0;
                fx       <= '0;
            end else if (req_now) begin
                fetching <= (fx != 9'(ACTIVE_PIX - 1));
                fx       <= fx + 9'd1;
                fph      <= FPH_W'(1);
                pix_x    <= fx[7:0];
                pix_y    <= 8'(line - 9'(VBLANK_END));
            end else if (fetching) begin
                fph <= (fph == FPH_W'(CLK_PER_PIX - 1)) ? '0 : fph + FPH_W'(1);
            end
        end
    end

    assign px = pix_buf;
`endif

    always_comb begin
        c_col   = BLACK_COLOUR;
        c_blank = 1'b1;
        c_sync  = 1'b0;
        c_burst = 1'b0;
        c_ls    = (state == H_SYNC) && (hcnt == '0);
        c_fs    = c_ls && (line == '0);
        if (vs_line) begin
            c_sync = !(state == H_FRONT ||
                       (state == H_ACTIVE && hcnt >= VS_ACT_END));
        end else begin
            c_sync = (state == H_SYNC);
            if (state == H_BURST) begin
                c_burst = 1'b1;
                c_col   = BURST_COLOUR;
            end
        end
        if (act_line && state == H_ACTIVE) begin
            c_blank = 1'b0;
            c_col   = px;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colour_num  <= BLACK_COLOUR;
            blank       <= 1'b1;
            sync        <= 1'b0;
            burst       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            colour_num  <= c_col;
            blank       <= c_blank;
            sync        <= c_sync;
            burst       <= c_burst;
            line_start  <= c_ls;
            frame_start <= c_fs;
        end
    end

endmodule

// File: tb/tb_ntsc_line_sequencer.sv
// Bench for ntsc_line_sequencer with a shortened field (9 lines) and full
// 3178-clk lines; per-clk reference model plus directed boundary checks.
module tb_ntsc_line_sequencer;

    localparam int VS    = 3;
    localparam int VBE   = 4;
    localparam int ACT   = 3;
    localparam int TOT   = 9;
    localparam int LINE  = 3178;
    localparam int FRAME = LINE * TOT;
    localparam int A0    = 545;
    localparam int REQ0  = 541;
    localparam int BUR0  = 265;
    localparam logic [5:0] BARS [8] =
        '{6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h26, 6'h22, 6'h0F};
`ifdef SEQ_TESTPATTERN_EN
    localparam int EXP_REQ = 0;
    localparam int EXP_FRL = -1;
    localparam int EXP_FRP = -1;
`else
    localparam int EXP_REQ = 256;
    localparam int EXP_FRL = VBE;
    localparam int EXP_FRP = REQ0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] pix_colour = 6'h15;
    logic       pix_req;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [5:0] colour_num;
    logic       sync;
    logic       blank;
    logic       burst;
    logic       line_start;
    logic       frame_start;

    int n_chk = 0;
    int n_fail = 0;
    int ln, pos;
    int e_sync, e_burst, e_blank, e_col, e_req, e_ls, e_fs;
    int n_ls, n_fs, first_ln, first_pos;
    int sync_cnt [TOT];
    int burst_cnt [TOT];
    int req_cnt [TOT];
    int burst_first [TOT];

    logic       v1 = 1'b0;
    logic       v2 = 1'b0;
    logic [5:0] x1 = '0;
    logic [5:0] x2 = '0;

    ntsc_line_sequencer #(
        .VSYNC_LINES  (VS),
        .VBLANK_END   (VBE),
        .ACTIVE_LINES (ACT),
        .TOTAL_LINES  (TOT),
        .PIX_LAT      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_colour  (pix_colour),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .colour_num  (colour_num),
        .sync        (sync),
        .blank       (blank),
        .burst       (burst),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    // Pixel source: data valid exactly 2 clk after the request, junk otherwise.
    initial forever begin
        @(negedge clk);
        pix_colour = v2 ? x2 : 6'h15;
        v2 = v1;
        x2 = x1;
        v1 = pix_req;
        x1 = pix_x[5:0];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        e_sync = 0; e_burst = 0; e_blank = 0; e_col = 0;
        e_req = 0; e_ls = 0; e_fs = 0;
        n_ls = 0; n_fs = 0; first_ln = -1; first_pos = -1;
        for (int i = 0; i < TOT; i++) begin
            sync_cnt[i] = 0;
            burst_cnt[i] = 0;
            req_cnt[i] = 0;
            burst_first[i] = -1;
        end
    endtask

    function automatic logic [5:0] px_val(int n);
`ifdef SEQ_TESTPATTERN_EN
        return BARS[n / 32];
`else
        return 6'(n % 64);
`endif
    endfunction

    task automatic step();
        logic aline, act, ebu, ereq;
        logic [5:0] ecol;
        int n;
        @(negedge clk);
        aline = (ln >= VBE) && (ln < VBE + ACT);
        act   = aline && pos >= A0 && pos < A0 + 2560;
        ebu   = (ln >= VS) && pos >= BUR0 && pos < BUR0 + 126;
        n     = (pos >= REQ0) ? (pos - REQ0) / 10 : 0;
        ereq  = aline && pos >= REQ0 && pos <= REQ0 + 2550 &&
                ((pos - REQ0) % 10 == 0);
`ifdef SEQ_TESTPATTERN_EN
        ereq  = 1'b0;
`endif
        ecol  = act ? px_val((pos - A0) / 10) : (ebu ? 6'h08 : 6'h0F);
        if (sync !== ((ln < VS) ? (pos < LINE - 235) : (pos < 235))) e_sync++;
        if (burst !== ebu) e_burst++;
        if (blank !== !act) e_blank++;
        if (colour_num !== ecol) e_col++;
        if (pix_req !== ereq ||
            (ereq && (pix_x !== 8'(n) || pix_y !== 8'(ln - VBE)))) e_req++;
        if (line_start !== (pos == 0)) e_ls++;
        if (frame_start !== (pos == 0 && ln == 0)) e_fs++;
        sync_cnt[ln]  += int'(sync);
        burst_cnt[ln] += int'(burst);
        req_cnt[ln]   += int'(pix_req);
        if (burst && burst_first[ln] < 0) burst_first[ln] = pos;
        if (pix_req && first_ln < 0) begin
            first_ln  = ln;
            first_pos = pos;
        end
        n_ls += int'(line_start);
        n_fs += int'(frame_start);
        if (aline && pos == A0 + 2560)
            check("after_px255", 32'({blank, colour_num}), 32'h4F);
        pos++;
        if (pos == LINE) begin
            pos = 0;
            ln  = (ln + 1) % TOT;
        end
    endtask

    initial begin
        clear();
        repeat (3) @(negedge clk);
        check("rst_colour", 32'(colour_num), 32'h0F);
        check("rst_flags", 32'({pix_req, sync, blank, burst, line_start, frame_start}), 32'h08);
        check("rst_pix", 32'({pix_x, pix_y}), 0);
        reset = 1'b0;
        ln = 0;
        pos = 0;

        repeat (FRAME) step();
        check("sync_model", e_sync, 0);
        check("burst_model", e_burst, 0);
        check("blank_model", e_blank, 0);
        check("colour_model", e_col, 0);
        check("req_model", e_req, 0);
        check("line_start_model", e_ls, 0);
        check("frame_start_model", e_fs, 0);
        check("line_starts", n_ls, TOT);
        check("frame_starts", n_fs, 1);
        check("vs_sync_len", sync_cnt[0], 2943);
        check("vs_burst_len", burst_cnt[1], 0);
        check("hs_sync_len", sync_cnt[VS], 235);
        check("burst_len", burst_cnt[VS], 126);
        check("burst_start", burst_first[VS], BUR0);
        check("act_reqs", req_cnt[VBE], EXP_REQ);
        check("last_act_reqs", req_cnt[VBE + ACT - 1], EXP_REQ);
        check("vblank_reqs", req_cnt[VS], 0);
        check("post_reqs", req_cnt[TOT - 1], 0);

        step();
        check("wrap_frame_start", 32'({frame_start, line_start, sync}), 32'h7);

        // Advance to active line 5, pixel 50's request clk.
        repeat (5 * LINE + 1041) step();
        check("pre_reset_blank", 32'(blank), 0);
        #2 reset = 1'b1;
        #1;
        check("async_colour", 32'(colour_num), 32'h0F);
        check("async_flags", 32'({pix_req, sync, blank, burst, line_start, frame_start}), 32'h08);
        @(negedge clk);
        reset = 1'b0;
        ln = 0;
        pos = 0;
        clear();

        repeat (VBE * LINE + 600) step();
        check("post_reset_model", e_sync + e_burst + e_blank + e_col + e_req + e_ls + e_fs, 0);
        check("post_reset_fs", n_fs, 1);
        check("first_req_line", first_ln, EXP_FRL);
        check("first_req_pos", first_pos, EXP_FRP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
